program_counter: RTL and testbench
==================================

PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter RESET_ADDR, default 32'h0004_0000: base address of the instruction region and the PC reset value.
REQ-003 Parameter STEP, default 32'd4: byte increment per clock; SHALL be a nonzero multiple of 4.
REQ-004 clk  input  1  rising-edge clock; all state updates on posedge clk only.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 PC  output  32  current instruction byte address, driven directly from a register.
REQ-007 line_index  output  32  word index into instruction memory, equal to (PC - RESET_ADDR) >> 2, modulo 2^32; combinational from PC.
REQ-008 pc_valid  output  1  high once PC has been loaded by reset; low before the first reset.
REQ-009 Ports SHALL appear in the order clk, rst, PC, line_index, pc_valid.
REQ-010 Instantiations connecting only clk, rst and PC SHALL be legal; line_index and pc_valid may be left unconnected.

Function
REQ-011 On posedge clk with rst=1: PC <= RESET_ADDR and pc_valid <= 1.
REQ-012 On posedge clk with rst=0 and pc_valid=1: PC <= PC + STEP.
REQ-013 On posedge clk with rst=0 and pc_valid=0: PC and pc_valid SHALL hold their current values.
REQ-014 Latency: PC SHALL change exactly one edge after the controlling condition; there is no combinational path from rst to PC.
REQ-015 Addition SHALL be 32-bit unsigned, modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag and no stall.
REQ-016 line_index SHALL use 32-bit modular subtraction, so a PC below RESET_ADDR yields a wrapped value.
REQ-017 PC[1:0] SHALL always be 2'b00 when RESET_ADDR and STEP are word-aligned.
REQ-018 Reset asserted mid-count SHALL override the increment on that same edge; PC becomes RESET_ADDR, not RESET_ADDR+STEP.
REQ-019 Reset held for N edges SHALL keep PC = RESET_ADDR for all N edges; counting resumes on the first edge with rst=0.
REQ-020 Reset SHALL be sampled only at posedge clk; a rst pulse entirely between edges SHALL have no effect.

Reset
REQ-021 Power-up PC value SHALL be treated as unknown in silicon.
REQ-022 For simulation, PC SHALL be initialized to RESET_ADDR and pc_valid to 0 at time zero, so line_index reads 0 and never X.
REQ-023 The first posedge with rst=1 SHALL establish PC=RESET_ADDR and pc_valid=1 regardless of prior state.
REQ-024 No asynchronous reset path SHALL exist.

Verification
REQ-025 rst=1 for 3 edges -> PC=32'h0004_0000, line_index=0, pc_valid=1 after each edge.
REQ-026 Release rst, then 5 edges -> PC = 0x40004, 0x40008, 0x4000C, 0x40010, 0x40014 and line_index = 1..5.
REQ-027 Assert rst on a single edge when PC=0x40010 -> PC=0x40000 after that edge, then 0x40004 on the next edge.
REQ-028 Pulse rst high between two edges with no posedge during the pulse -> PC keeps incrementing by 4 uninterrupted.
REQ-029 Instantiate with RESET_ADDR=32'hFFFF_FFF8, reset, then 3 edges -> PC = FFFF_FFFC, 0000_0000, 0000_0004 and line_index = 1, 2, 3.
REQ-030 No reset applied, clock running -> PC stays 0x40000 and pc_valid stays 0 under simulation init.

Source files
------------

// File: rtl/program_counter.sv
// Program counter: a word-aligned byte address that steps by STEP on every clock edge
// once it has been loaded by reset. It also reports the matching instruction-memory word
// index relative to the base of the instruction region.
module program_counter #(
  parameter logic [31:0] RESET_ADDR = 32'h0004_0000,
  parameter logic [31:0] STEP       = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  output logic [31:0] line_index,
  output logic        pc_valid
);

  // Silicon powers up unknown. The declaration initialisers give simulation a defined
  // time-zero state (PC at the base, not yet valid) so line_index never reads X.
  logic [31:0] pc_q    = RESET_ADDR;
  logic        valid_q = 1'b0;
  logic [31:0] pc_d;
  logic [31:0] pc_offset;

  // Next PC: step only after reset has loaded a known address; otherwise hold.
  // The addition wraps modulo 2^32 with no flag and no stall.
  always_comb begin
    pc_d = pc_q;
    if (valid_q) begin
      pc_d = pc_q + STEP;
    end
  end

  // State update: synchronous reset takes priority over the increment on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_ADDR;
      valid_q <= 1'b1;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_q;
    end
  end

  // Word index into instruction memory; a PC below the base wraps modulo 2^32.
  always_comb begin
    pc_offset  = pc_q - RESET_ADDR;
    line_index = pc_offset >> 2;
  end

  assign PC       = pc_q;
  assign pc_valid = valid_q;

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;

  localparam logic [31:0] RA_A = 32'h0004_0000;
  localparam logic [31:0] RA_B = 32'hFFFF_FFF8;
  localparam logic [31:0] STEP = 32'd4;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0;
  logic        rst_b = 1'b0;
  logic [31:0] pc_a, idx_a, pc_b, idx_b;
  logic        valid_a, valid_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  program_counter #(.RESET_ADDR(RA_A), .STEP(STEP)) dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .PC        (pc_a),
    .line_index(idx_a),
    .pc_valid  (valid_a)
  );

  program_counter #(.RESET_ADDR(RA_B), .STEP(STEP)) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .PC        (pc_b),
    .line_index(idx_b),
    .pc_valid  (valid_b)
  );

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic [31:0] idx;
    logic        valid;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive reset levels, take one rising edge, sample 1 time unit later.
  task automatic step(input logic ra, input logic rb);
    rst_a = ra;
    rst_b = rb;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic [31:0] pc);
    vec_t v;
    v.rst   = r;
    v.pc    = pc;
    v.idx   = (pc - RA_A) / 4;
    v.valid = 1'b1;
    return v;
  endfunction

  // Reference model state: valid flag and edges counted since the last reset.
  logic        m_valid;
  logic [31:0] m_k;
  logic        r;

  initial begin
    // Time-zero state before any edge.
    #1;
    chk("init_pc_a", pc_a, RA_A);
    chk("init_idx_a", idx_a, 32'd0);
    chk("init_valid_a", {31'd0, valid_a}, 32'd0);

    // Clock running, no reset: both instances hold.
    repeat (3) step(1'b0, 1'b0);
    chk("noreset_pc_a", pc_a, RA_A);
    chk("noreset_valid_a", {31'd0, valid_a}, 32'd0);
    chk("noreset_pc_b", pc_b, RA_B);
    chk("noreset_idx_b", idx_b, 32'd0);

    // Wrap-around instance: reset then three increments through 2^32.
    step(1'b0, 1'b1);
    chk("wrap_rst_pc", pc_b, 32'hFFFF_FFF8);
    chk("wrap_rst_valid", {31'd0, valid_b}, 32'd1);
    step(1'b0, 1'b0);
    chk("wrap_pc1", pc_b, 32'hFFFF_FFFC);
    chk("wrap_idx1", idx_b, 32'd1);
    step(1'b0, 1'b0);
    chk("wrap_pc2", pc_b, 32'h0000_0000);
    chk("wrap_idx2", idx_b, 32'd2);
    step(1'b0, 1'b0);
    chk("wrap_pc3", pc_b, 32'h0000_0004);
    chk("wrap_idx3", idx_b, 32'd3);
    chk("hold_pc_a", pc_a, RA_A);

    // Table: reset held 3 edges, count 5, mid-count reset at 0x40010, resume.
    repeat (3) vecs.push_back(mk(1'b1, 32'h0004_0000));
    for (int i = 1; i <= 5; i++) vecs.push_back(mk(1'b0, RA_A + 4 * i));
    vecs.push_back(mk(1'b1, 32'h0004_0000));
    for (int i = 1; i <= 4; i++) vecs.push_back(mk(1'b0, RA_A + 4 * i));
    vecs.push_back(mk(1'b1, 32'h0004_0000));
    vecs.push_back(mk(1'b0, 32'h0004_0004));
    foreach (vecs[i]) begin
      step(vecs[i].rst, 1'b0);
      chk($sformatf("vec%0d_pc", i), pc_a, vecs[i].pc);
      chk($sformatf("vec%0d_idx", i), idx_a, vecs[i].idx);
      chk($sformatf("vec%0d_valid", i), {31'd0, valid_a}, {31'd0, vecs[i].valid});
    end

    // Reset pulse entirely between edges has no effect.
    #2 rst_a = 1'b1;
    #2 rst_a = 1'b0;
    step(1'b0, 1'b0);
    chk("pulse_pc1", pc_a, 32'h0004_0008);
    step(1'b0, 1'b0);
    chk("pulse_pc2", pc_a, 32'h0004_000C);

    // Randomized reset pattern against the model.
    m_valid = 1'b1;
    m_k     = 32'd3;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 7) == 0);
      step(r, 1'b0);
      if (r) m_k = 32'd0;
      else if (m_valid) m_k = m_k + 32'd1;
      if (r) m_valid = 1'b1;
      chk("rand_pc", pc_a, RA_A + m_k * STEP);
      chk("rand_idx", idx_a, m_k);
      chk("rand_valid", {31'd0, valid_a}, {31'd0, m_valid});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
